fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Round-robin scheduler that shares one fixed-latency, fully pipelined FP32 adder among NUM_REQ convolution accumulation lanes.
- Accepts operand pairs on per-lane valid/ready handshakes and issues at most one pair per cycle to the adder.
- Tracks each issued lane ID through a tag pipeline matched to the adder latency, then returns every sum tagged with its lane ID.
- Sits between the MAC lanes and the shared adder (alignment, add, LZC normalisation, round).

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- ID_W, 2, lane ID width; 2^ID_W >= NUM_REQ.
- DATA_W, 32, operand/result width (IEEE-754 single).
- ADD_LAT, 3, adder latency in cycles from add_valid to add_result_valid (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- hold  in  1  when 1, no new grants are made; in-flight operations drain.
- req_valid  in  NUM_REQ  per-lane request valid.
- req_a  in  NUM_REQ*DATA_W  operand A; lane i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B; same packing as req_a.
- req_ready  out  NUM_REQ  per-lane grant (one-hot or zero).
- add_valid  out  1  issue strobe to the adder.
- add_a  out  DATA_W  operand A to the adder.
- add_b  out  DATA_W  operand B to the adder.
- add_result_valid  in  1  adder output valid.
- add_result  in  DATA_W  adder sum.
- rsp_valid  out  1  response valid; no backpressure.
- rsp_id  out  ID_W  lane ID of the response.
- rsp_data  out  DATA_W  sum.
- busy  out  1  1 while any operation is issued or in flight.
- seq_err  out  1  sticky tag/result misalignment flag.

Behaviour:
- Reset: all outputs 0, tag pipeline cleared, seq_err=0, round-robin pointer ptr=NUM_REQ-1 (lane 0 has first priority).
- Grant (combinational):
  - Lane priority order starts at ptr+1, modulo NUM_REQ.
  - req_ready = one-hot of the first lane with req_valid=1 in that order.
  - req_ready is all-zero when hold=1 or RST=1.
  - req_ready must not depend on any other lane's ready.
- Transfer occurs when req_valid[i] & req_ready[i]. On a transfer, ptr <= i. With no transfer, ptr holds.
- Issue register, one cycle after transfer:
  - add_valid=1; add_a/add_b = the granted lane's operands; issue-tag = {1, i}.
  - add_valid=0 in cycles with no transfer; add_a/add_b hold their last values.
- Tag pipeline:
  - Shift register of ADD_LAT entries {valid, id}, loaded from the issue-tag every cycle (including empty tags).
  - The tail entry is aligned with add_result_valid.
- Response register, one cycle after add_result_valid: rsp_valid=1, rsp_id=tail id, rsp_data=add_result.
- Latency: transfer at cycle T -> rsp_valid at T+ADD_LAT+2. Throughput is one operation per cycle in aggregate.
- Misalignment:
  - If add_result_valid differs from the tail valid bit, set seq_err=1; it stays 1 until RST.
  - Result valid with empty tail: rsp_valid stays 0 (result dropped).
  - Tail valid with no result: no response is issued.
- busy = add_valid | any tag valid | rsp_valid.
- hold asserted mid-stream: the grant is removed in the same cycle. Issued operations complete and respond normally. busy falls once the pipeline is empty.
- Single requester held valid: granted every cycle (ptr equal to its own index still grants it).
- Simultaneous events: a new transfer, a pipeline shift and a response all occur in the same cycle without interference.
- RST mid-operation: in-flight tags are discarded; adder results arriving afterwards raise no rsp_valid. seq_err is not set by these results, because the reset also clears the pipeline that the adder is still flushing. For this reason, add_result_valid is masked for ADD_LAT cycles after reset.

Test Plan:
1. Lane 2 only, a=0x3F800000 (1.0), b=0x40000000 (2.0), adder model returns 0x40400000 -> req_ready=4'b0100 at T; add_valid at T+1; rsp_valid at T+ADD_LAT+2 with rsp_id=2, rsp_data=0x40400000; busy returns to 0.
2. All four lanes valid continuously after reset -> grants 0,1,2,3,0,1… on consecutive cycles; rsp_id sequence matches with no gaps; 4 back-to-back responses.
3. Lanes 1 and 3 valid with ptr=1 (after a lane-1 grant) -> lane 3 is granted first, then 1, alternating; no lane starves.
4. hold=1 for 5 cycles while lanes valid with 2 operations in flight -> req_ready=0 throughout; the 2 responses still arrive; busy=0 before hold is released; grants resume from the saved ptr.
5. Adder model drops one add_result_valid -> seq_err=1 on that cycle and stays 1 through subsequent traffic until RST.
6. RST asserted one cycle after 3 issues -> all outputs 0 next cycle; late adder results produce no rsp_valid and no seq_err; the next request is served with lane 0 priority.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin scheduler sharing one pipelined FP32 adder among NUM_REQ lanes.
// Lane IDs ride a tag pipeline matched to the adder latency; sums return with their lane ID.
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      add_valid,
    output logic [DATA_W-1:0]         add_a,
    output logic [DATA_W-1:0]         add_b,
    input  logic                      add_result_valid,
    input  logic [DATA_W-1:0]         add_result,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      seq_err
);

    localparam int MW = $clog2(ADD_LAT + 1);

    logic [ID_W-1:0]   ptr_q;
    logic              addValid_q;
    logic [DATA_W-1:0] addA_q;
    logic [DATA_W-1:0] addB_q;
    logic [ID_W-1:0]   issueId_q;
    logic              tagValid_q [ADD_LAT];
    logic [ID_W-1:0]   tagId_q    [ADD_LAT];
    logic              rspValid_q;
    logic [ID_W-1:0]   rspId_q;
    logic [DATA_W-1:0] rspData_q;
    logic              seqErr_q;
    logic [MW-1:0]     resultMask_q;

    logic              grantFound;
    logic [ID_W-1:0]   grantId;
    logic              grantEn;
    logic [DATA_W-1:0] selA;
    logic [DATA_W-1:0] selB;
    logic              resValid;
    logic              tailValid;
    logic [ID_W-1:0]   tailId;
    logic              rspValid_d;
    logic              anyTag;

    // Lanes above ptr take precedence over lanes at or below it; lowest index wins within each group.
    always_comb begin
        grantFound = 1'b0;
        grantId    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i <= int'(ptr_q))) begin
                grantFound = 1'b1;
                grantId    = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(ptr_q))) begin
                grantFound = 1'b1;
                grantId    = ID_W'(i);
            end
        end
    end

    assign grantEn = grantFound & ~hold & ~RST;

    always_comb begin
        req_ready = '0;
        selA      = '0;
        selB      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grantEn && (grantId == ID_W'(i));
            if (grantId == ID_W'(i)) begin
                selA = req_a[i*DATA_W +: DATA_W];
                selB = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Results still draining from before a reset are ignored until the adder has flushed.
    assign resValid   = add_result_valid && (resultMask_q == '0);
    assign tailValid  = tagValid_q[ADD_LAT-1];
    assign tailId     = tagId_q[ADD_LAT-1];
    assign rspValid_d = resValid & tailValid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q        <= ID_W'(NUM_REQ - 1);
            addValid_q   <= 1'b0;
            addA_q       <= '0;
            addB_q       <= '0;
            issueId_q    <= '0;
            for (int k = 0; k < ADD_LAT; k++) begin
                tagValid_q[k] <= 1'b0;
                tagId_q[k]    <= '0;
            end
            rspValid_q   <= 1'b0;
            rspId_q      <= '0;
            rspData_q    <= '0;
            seqErr_q     <= 1'b0;
            resultMask_q <= MW'(ADD_LAT);
        end else begin
            addValid_q <= grantEn;
            if (grantEn) begin
                ptr_q     <= grantId;
                addA_q    <= selA;
                addB_q    <= selB;
                issueId_q <= grantId;
            end
            tagValid_q[0] <= addValid_q;
            tagId_q[0]    <= issueId_q;
            for (int k = 1; k < ADD_LAT; k++) begin
                tagValid_q[k] <= tagValid_q[k-1];
                tagId_q[k]    <= tagId_q[k-1];
            end
            if (resultMask_q != '0) begin
                resultMask_q <= resultMask_q - MW'(1);
            end
            rspValid_q <= rspValid_d;
            if (rspValid_d) begin
                rspId_q   <= tailId;
                rspData_q <= add_result;
            end
            if (resValid != tailValid) begin
                seqErr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        anyTag = 1'b0;
        for (int k = 0; k < ADD_LAT; k++) begin
            anyTag = anyTag | tagValid_q[k];
        end
    end

    assign add_valid = addValid_q;
    assign add_a     = addA_q;
    assign add_b     = addB_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;
    assign seq_err   = seqErr_q;
    assign busy      = addValid_q | anyTag | rspValid_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: reference round-robin model, behavioural FP adder
// with optional result drop, and a scoreboard of expected tagged sums with arrival cycle.
module tb_fp_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DATA_W  = 32;
    localparam int ADD_LAT = 3;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [31:0]       cyc;
    } exp_t;

    logic                      CLK;
    logic                      RST;
    logic                      hold;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      add_valid;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic                      add_result_valid;
    logic [DATA_W-1:0]         add_result;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
    logic                      seq_err;

    int          checks;
    int          failures;
    logic [31:0] cyc;
    int          mPtr;
    int          opIdx;
    bit          skipPush;
    bit          dropArm;
    exp_t        expQ[$];

    logic              pipeV [ADD_LAT];
    logic [DATA_W-1:0] pipeD [ADD_LAT];

    fp_add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .hold             (hold),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ready        (req_ready),
        .add_valid        (add_valid),
        .add_a            (add_a),
        .add_b            (add_b),
        .add_result_valid (add_result_valid),
        .add_result       (add_result),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data),
        .busy             (busy),
        .seq_err          (seq_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 32'd1;

    // Single <-> double conversion for normal, in-range values (all operands here are such).
    function automatic real fromSingle(input logic [31:0] s);
        logic [10:0] e;
        logic [63:0] d;
        e = {3'b000, s[30:23]} + 11'd896;
        d = {s[31], e, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] toSingle(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpSum(input logic [31:0] a, input logic [31:0] b);
        return toSingle(fromSingle(a) + fromSingle(b));
    endfunction

    // Behavioural adder: ADD_LAT-stage pipeline; dropArm suppresses the valid of the op issued that cycle.
    always @(posedge CLK) begin
        pipeV[0] <= add_valid && !dropArm;
        pipeD[0] <= fpSum(add_a, add_b);
        for (int k = 1; k < ADD_LAT; k++) begin
            pipeV[k] <= pipeV[k-1];
            pipeD[k] <= pipeD[k-1];
        end
    end
    assign add_result_valid = pipeV[ADD_LAT-1];
    assign add_result       = pipeD[ADD_LAT-1];

    // Every response must match the oldest expected entry, including its arrival cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && rsp_valid) begin
            checks++;
            assert (expQ.size() > 0) else begin
                failures++;
                $error("[TB] FAIL unexpected_rsp observed rsp_valid=1 id=%0d data=%h expected rsp_valid=0", rsp_id, rsp_data);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                assert ((rsp_id === e.id) && (rsp_data === e.data) && (cyc === e.cyc)) else begin
                    failures++;
                    $error("[TB] FAIL rsp observed id=%0d data=%h cyc=%0d expected id=%0d data=%h cyc=%0d",
                           rsp_id, rsp_data, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of requests, checks the grant against the round-robin model and
    // records the expected response for any transfer.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic h, input bit keepOps);
        logic [NUM_REQ-1:0] expReady;
        int                 idx;
        bit                 found;
        exp_t               e;
        req_valid = valid;
        hold      = h;
        if (!keepOps) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a[i*DATA_W +: DATA_W] = toSingle(real'(opIdx * 8 + i + 1));
                req_b[i*DATA_W +: DATA_W] = toSingle(0.5 * real'(i + 1));
            end
        end
        @(negedge CLK);
        expReady = '0;
        found    = 1'b0;
        idx      = 0;
        if (!h) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int cand;
                cand = (mPtr + k) % NUM_REQ;
                if (!found && valid[cand]) begin
                    found          = 1'b1;
                    idx            = cand;
                    expReady[cand] = 1'b1;
                end
            end
        end
        checkOutput("grant", 64'(req_ready), 64'(expReady));
        if (found) begin
            mPtr = idx;
            if (!skipPush) begin
                e.id   = ID_W'(idx);
                e.data = fpSum(req_a[idx*DATA_W +: DATA_W], req_b[idx*DATA_W +: DATA_W]);
                e.cyc  = cyc + 32'(ADD_LAT + 2);
                expQ.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
        opIdx++;
    endtask

    task automatic applyReset(input int n);
        RST       = 1'b1;
        req_valid = '0;
        hold      = 1'b0;
        expQ.delete();
        repeat (n) @(posedge CLK);
        #1;
        RST  = 1'b0;
        mPtr = NUM_REQ - 1;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        req_valid = '0;
        hold      = 1'b0;
        n         = 0;
        while ((expQ.size() != 0) && (n < budget)) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        opIdx     = 0;
        skipPush  = 1'b0;
        dropArm   = 1'b0;
        req_a     = '0;
        req_b     = '0;
        applyReset(6);

        // Reset state
        checkOutput("rst_add_valid", 64'(add_valid), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_seq_err", 64'(seq_err), 64'd0);

        // Single lane 2 transaction: 1.0 + 2.0
        $display("[TB] test 1: lane 2 single op");
        req_a[2*DATA_W +: DATA_W] = 32'h3F80_0000;
        req_b[2*DATA_W +: DATA_W] = 32'h4000_0000;
        applyStimulus(4'b0100, 1'b0, 1'b1);
        req_valid = '0;
        checkOutput("t1_add_valid", 64'(add_valid), 64'd1);
        checkOutput("t1_add_a", 64'(add_a), 64'h3F80_0000);
        checkOutput("t1_add_b", 64'(add_b), 64'h4000_0000);
        checkOutput("t1_model_sum", 64'(expQ[0].data), 64'h4040_0000);
        waitDrain(20);
        checkOutput("t1_busy_idle", 64'(busy), 64'd0);

        // All lanes continuously valid from reset
        $display("[TB] test 2: four lanes round robin");
        applyReset(2);
        for (int n = 0; n < 8; n++) applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("t2_busy", 64'(busy), 64'd1);
        waitDrain(20);

        // Lanes 1 and 3 alternate after a lane-1 grant
        $display("[TB] test 3: lanes 1 and 3 alternate");
        applyStimulus(4'b0010, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(4'b1010, 1'b0, 1'b0);
        waitDrain(20);

        // Hold with two operations in flight
        $display("[TB] test 4: hold drains pipeline");
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t4_busy_inflight", 64'(busy), 64'd1);
        for (int n = 0; n < 4; n++) applyStimulus(4'b0111, 1'b1, 1'b0);
        checkOutput("t4_busy_drained", 64'(busy), 64'd0);
        checkOutput("t4_pending", 64'(expQ.size()), 64'd0);
        applyStimulus(4'b0111, 1'b1, 1'b0);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        waitDrain(20);

        // Adder drops one result
        $display("[TB] test 5: dropped adder result");
        dropArm  = 1'b1;
        skipPush = 1'b1;
        applyStimulus(4'b0001, 1'b0, 1'b0);
        skipPush = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        dropArm = 1'b0;
        checkOutput("t5_seq_err_before", 64'(seq_err), 64'd0);
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t5_seq_err_set", 64'(seq_err), 64'd1);
        checkOutput("t5_no_rsp", 64'(rsp_valid), 64'd0);
        for (int n = 0; n < 4; n++) applyStimulus(4'b1111, 1'b0, 1'b0);
        waitDrain(20);
        checkOutput("t5_seq_err_sticky", 64'(seq_err), 64'd1);

        // Reset mid-operation
        $display("[TB] test 6: reset with ops in flight");
        for (int n = 0; n < 3; n++) applyStimulus(4'b0111, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyReset(1);
        checkOutput("t6_add_valid", 64'(add_valid), 64'd0);
        checkOutput("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_seq_err", 64'(seq_err), 64'd0);
        repeat (4) applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t6_seq_err_late", 64'(seq_err), 64'd0);
        applyStimulus(4'b1001, 1'b0, 1'b0);
        waitDrain(20);
        checkOutput("t6_seq_err_end", 64'(seq_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
